key_conditioner: RTL and testbench

- Parametrised N-channel conditioner for the board push-buttons, sitting between the raw KEY pins and the galaga game logic.
- Each channel has:
  - a 2-flop synchroniser;
  - a counter-based debouncer;
  - single-cycle press and release strobes;
  - optional auto-repeat strobes for held keys (fire/move).
- It replaces ad-hoc direct use of KEY bits in the game FSMs.

---
 rtl/galaga_input_pkg.sv | 27 ++
 rtl/key_debounce_channel.sv | 150 +++++++++++++++
 rtl/key_conditioner.sv | 53 +++++
 tb/tb_key_conditioner.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/galaga_input_pkg.sv
// rtl/galaga_input_pkg.sv - shared types and 50 MHz timing defaults for the key conditioner
// Purpose: per-channel FSM state encoding, default cycle counts, counter sizing helper.
// Ports: none (package).
package galaga_input_pkg;

   typedef enum logic [2:0] {
      RELEASED,
      PRESS_WAIT,
      HELD,
      REPEATING,
      RELEASE_WAIT
   } key_state_t;

   // Defaults for a 50 MHz CLOCK_50
   localparam int DEF_DEBOUNCE_CYCLES = 250000;    // 5 ms
   localparam int DEF_REPEAT_DELAY    = 25000000;  // 0.5 s
   localparam int DEF_REPEAT_RATE     = 5000000;   // 0.1 s

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// rtl/key_debounce_channel.sv - one push-button channel: synchroniser, debounce FSM, auto-repeat
// Purpose: turns one raw, bouncing pin into a clean level plus press/release/repeat strobes.
// Ports:
//   i_clk      system clock
//   i_rst      asynchronous active-high reset
//   i_key_raw  unsynchronised pin
//   o_level    debounced pressed level (1 = pressed)
//   o_press    1-cycle strobe on accepted press
//   o_release  1-cycle strobe on accepted release
//   o_repeat   1-cycle strobe per auto-repeat tick
module key_debounce_channel
   import galaga_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key_raw,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_repeat
);

   localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)) + 1;
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] DLY_LAST  = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);
   // Synchroniser resets to the idle pin value so leaving reset never looks like a press
   localparam logic REL_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   logic          r_s1, r_s2;
   key_state_t    r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_level, w_level_nxt;
   logic          r_press, w_press_nxt;
   logic          r_release, w_release_nxt;
   logic          r_repeat, w_repeat_nxt;
   logic          w_pressed;

   assign w_pressed = (ACTIVE_LOW != 0) ? ~r_s2 : r_s2;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1      <= REL_PIN;
         r_s2      <= REL_PIN;
         r_state   <= RELEASED;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_repeat  <= 1'b0;
      end else begin
         r_s1      <= i_key_raw;
         r_s2      <= r_s1;
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_level   <= w_level_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
         r_repeat  <= w_repeat_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_level_nxt   = r_level;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      w_repeat_nxt  = 1'b0;
      case (r_state)
         RELEASED: begin
            if (w_pressed) begin
               w_state_nxt = PRESS_WAIT;
               w_cnt_nxt   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!w_pressed) begin
               w_state_nxt = RELEASED;
               w_cnt_nxt   = '0;
            end else if (r_cnt == DEB_LAST) begin
               w_state_nxt = HELD;
               w_level_nxt = 1'b1;
               w_press_nxt = 1'b1;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         HELD: begin
            if (!w_pressed) begin
               w_state_nxt = RELEASE_WAIT;
               w_cnt_nxt   = '0;
            end else if (REPEAT_EN != 0) begin
               if (r_cnt == DLY_LAST) begin
                  w_state_nxt  = REPEATING;
                  w_repeat_nxt = 1'b1;
                  w_cnt_nxt    = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end else begin
               w_cnt_nxt = '0;
            end
         end
         REPEATING: begin
            if (!w_pressed) begin
               w_state_nxt = RELEASE_WAIT;
               w_cnt_nxt   = '0;
            end else if (r_cnt == RATE_LAST) begin
               w_repeat_nxt = 1'b1;
               w_cnt_nxt    = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         RELEASE_WAIT: begin
            // A bounce back to pressed keeps the level and restarts the repeat delay
            if (w_pressed) begin
               w_state_nxt = HELD;
               w_cnt_nxt   = '0;
            end else if (r_cnt == DEB_LAST) begin
               w_state_nxt   = RELEASED;
               w_level_nxt   = 1'b0;
               w_release_nxt = 1'b1;
               w_cnt_nxt     = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = RELEASED;
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b0;
         end
      endcase
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_repeat  = r_repeat;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - N-channel push-button conditioner for the galaga game logic
// Purpose: one independent debounce/repeat channel per KEY pin, plus an any-press summary.
// Ports:
//   CLOCK_50     system clock
//   Reset        asynchronous active-high reset
//   key_raw      unsynchronised button pins
//   key_level    debounced pressed level (1 = pressed)
//   key_press    1-cycle strobe on accepted press
//   key_release  1-cycle strobe on accepted release
//   key_repeat   1-cycle strobe per auto-repeat tick
//   any_press    OR of key_press
module key_conditioner
   import galaga_input_pkg::*;
#(
   parameter int N_KEYS          = 4,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic              CLOCK_50,
   input  logic              Reset,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_repeat,
   output logic              any_press
);

   for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
      key_debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_EN       (REPEAT_EN),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_RATE     (REPEAT_RATE),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_chan (
         .i_clk     (CLOCK_50),
         .i_rst     (Reset),
         .i_key_raw (key_raw[g]),
         .o_level   (key_level[g]),
         .o_press   (key_press[g]),
         .o_release (key_release[g]),
         .o_repeat  (key_repeat[g])
      );
   end

   // key_press bits are already registered, so this stays aligned with them
   assign any_press = |key_press;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed table-driven bench for key_conditioner
module tb_key_conditioner;

   logic       clk;
   logic       rst;
   logic [3:0] key_raw;
   logic [3:0] key_level, key_press, key_release, key_repeat;
   logic       any_press;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic [3:0] raw;
      int         n;
      logic [3:0] lvl;
      logic [3:0] prs;
      logic [3:0] rel;
      logic [3:0] rep;
   } vec_t;

   vec_t vec[$];

   key_conditioner #(
      .N_KEYS          (4),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_EN       (1),
      .REPEAT_DELAY    (8),
      .REPEAT_RATE     (3),
      .ACTIVE_LOW      (1)
   ) dut (
      .CLOCK_50    (clk),
      .Reset       (rst),
      .key_raw     (key_raw),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .key_repeat  (key_repeat),
      .any_press   (any_press)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic add(input logic [3:0] raw, input int n, input logic [3:0] lvl,
                      input logic [3:0] prs, input logic [3:0] rel, input logic [3:0] rep);
      vec_t v;
      v.raw = raw; v.n = n; v.lvl = lvl; v.prs = prs; v.rel = rel; v.rep = rep;
      vec.push_back(v);
   endtask

   task automatic check(input string name, input logic [3:0] lvl, input logic [3:0] prs,
                        input logic [3:0] rel, input logic [3:0] rep);
      logic [16:0] got, exp;
      got = {key_level, key_press, key_release, key_repeat, any_press};
      exp = {lvl, prs, rel, rep, |prs};
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got lvl=%b prs=%b rel=%b rep=%b any=%b, want lvl=%b prs=%b rel=%b rep=%b any=%b",
                  name, key_level, key_press, key_release, key_repeat, any_press,
                  lvl, prs, rel, rep, |prs);
      end
   endtask

   // Drive raw pins at the falling edge, sample #1 after the following rising edge
   task automatic step(input logic [3:0] raw);
      @(negedge clk);
      key_raw = raw;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // 1: reset release with idle pins
      add(4'hF, 20, 4'h0, 4'h0, 4'h0, 4'h0);
      // 2: key 1 press (7 edges), first repeat 8 later, next 3 later, release 7 edges after raw edge
      add(4'hD, 6, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'hD, 1, 4'h2, 4'h2, 4'h0, 4'h0);
      add(4'hD, 7, 4'h2, 4'h0, 4'h0, 4'h0);
      add(4'hD, 1, 4'h2, 4'h0, 4'h0, 4'h2);
      add(4'hD, 2, 4'h2, 4'h0, 4'h0, 4'h0);
      add(4'hD, 1, 4'h2, 4'h0, 4'h0, 4'h2);
      add(4'hF, 6, 4'h2, 4'h0, 4'h0, 4'h0);
      add(4'hF, 1, 4'h0, 4'h0, 4'h2, 4'h0);
      add(4'hF, 3, 4'h0, 4'h0, 4'h0, 4'h0);
      // 3: glitches of 3 and 4 cycles rejected; 5 cycles is the shortest accepted press
      add(4'hE, 3, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'hF, 8, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'hE, 4, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'hF, 8, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'hE, 5, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'hF, 1, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'hF, 1, 4'h1, 4'h1, 4'h0, 4'h0);
      add(4'hF, 4, 4'h1, 4'h0, 4'h0, 4'h0);
      add(4'hF, 1, 4'h0, 4'h0, 4'h1, 4'h0);
      add(4'hF, 3, 4'h0, 4'h0, 4'h0, 4'h0);
      // 4: key 2 held 29 cycles past acceptance, then released
      add(4'hB, 6, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'hB, 1, 4'h4, 4'h4, 4'h0, 4'h0);
      add(4'hB, 7, 4'h4, 4'h0, 4'h0, 4'h0);
      add(4'hB, 1, 4'h4, 4'h0, 4'h0, 4'h4);
      for (int k = 0; k < 7; k++) begin
         add(4'hB, 2, 4'h4, 4'h0, 4'h0, 4'h0);
         add(4'hB, 1, 4'h4, 4'h0, 4'h0, 4'h4);
      end
      add(4'hF, 6, 4'h4, 4'h0, 4'h0, 4'h0);
      add(4'hF, 1, 4'h0, 4'h0, 4'h4, 4'h0);
      add(4'hF, 10, 4'h0, 4'h0, 4'h0, 4'h0);
      // 5: keys 0 and 3 together, key 3 released while key 0 keeps repeating
      add(4'h6, 6, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'h6, 1, 4'h9, 4'h9, 4'h0, 4'h0);
      add(4'hE, 6, 4'h9, 4'h0, 4'h0, 4'h0);
      add(4'hE, 1, 4'h1, 4'h0, 4'h8, 4'h0);
      add(4'hE, 1, 4'h1, 4'h0, 4'h0, 4'h1);
      add(4'hE, 2, 4'h1, 4'h0, 4'h0, 4'h0);
      add(4'hE, 1, 4'h1, 4'h0, 4'h0, 4'h1);
      add(4'hF, 6, 4'h1, 4'h0, 4'h0, 4'h0);
      add(4'hF, 1, 4'h0, 4'h0, 4'h1, 4'h0);
      add(4'hF, 3, 4'h0, 4'h0, 4'h0, 4'h0);
      // release-side bounce on key 1: no release strobe, repeat delay restarts
      add(4'hD, 6, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'hD, 1, 4'h2, 4'h2, 4'h0, 4'h0);
      add(4'hF, 2, 4'h2, 4'h0, 4'h0, 4'h0);
      add(4'hD, 10, 4'h2, 4'h0, 4'h0, 4'h0);
      add(4'hD, 1, 4'h2, 4'h0, 4'h0, 4'h2);
      add(4'hF, 6, 4'h2, 4'h0, 4'h0, 4'h0);
      add(4'hF, 1, 4'h0, 4'h0, 4'h2, 4'h0);
      add(4'hF, 3, 4'h0, 4'h0, 4'h0, 4'h0);

      rst     = 1'b1;
      key_raw = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", 4'h0, 4'h0, 4'h0, 4'h0);
      rst = 1'b0;

      foreach (vec[i]) begin
         for (int c = 0; c < vec[i].n; c++) begin
            step(vec[i].raw);
            check($sformatf("row%0d.c%0d", i, c), vec[i].lvl, vec[i].prs, vec[i].rel, vec[i].rep);
         end
      end

      // 6: reset while key 1 is HELD
      for (int c = 0; c < 6; c++) begin
         step(4'hD);
         check($sformatf("rst_pre_wait%0d", c), 4'h0, 4'h0, 4'h0, 4'h0);
      end
      step(4'hD);
      check("rst_pre_press", 4'h2, 4'h2, 4'h0, 4'h0);
      for (int c = 0; c < 3; c++) begin
         step(4'hD);
         check($sformatf("rst_pre_held%0d", c), 4'h2, 4'h0, 4'h0, 4'h0);
      end
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_clear", 4'h0, 4'h0, 4'h0, 4'h0);
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("rst_held%0d", c), 4'h0, 4'h0, 4'h0, 4'h0);
      end
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step(4'hD);
         check($sformatf("rst_post_wait%0d", c), 4'h0, 4'h0, 4'h0, 4'h0);
      end
      step(4'hD);
      check("rst_post_press", 4'h2, 4'h2, 4'h0, 4'h0);
      for (int c = 0; c < 6; c++) begin
         step(4'hF);
         check($sformatf("rst_post_relwait%0d", c), 4'h2, 4'h0, 4'h0, 4'h0);
      end
      step(4'hF);
      check("rst_post_release", 4'h0, 4'h0, 4'h2, 4'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
